// File: rtl/rtc_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package rtc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DEB_PRESS = 3'd1,
    HELD      = 3'd2,
    REPEAT    = 3'd3,
    DEB_REL   = 3'd4
  } btn_state_t;

  localparam int TICK_DIV_50M = 49999;
  localparam int DEB_MS_DEF   = 10;
  localparam int HOLD_MS_DEF  = 500;
  localparam int RPT_MS_DEF   = 100;

  // Counter width large enough for the longest of the three tick intervals.
  function automatic int cnt_width(input int deb, input int hold, input int rpt);
    int m;
    m = hold;
    if (deb > m) begin
      m = deb;
    end else begin
      m = m;
    end
    if (rpt > m) begin
      m = rpt;
    end else begin
      m = m;
    end
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_fsm.sv
// One button: two-flop synchronizer plus debounce / hold / auto-repeat FSM.
// Auto-repeat is compiled only when BTN_AUTOREPEAT_EN is defined.
module btn_fsm
  import rtc_pkg::*;
#(
  parameter int DEB_MS  = DEB_MS_DEF,
  parameter int HOLD_MS = HOLD_MS_DEF,
  parameter int RPT_MS  = RPT_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic push_but,
  output logic pb_level,
  output logic pb_pulse
);

  localparam int CW = cnt_width(DEB_MS, HOLD_MS, RPT_MS);

  logic          meta_r;
  logic          sync_r;
  btn_state_t    state_r;
  btn_state_t    state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [CW-1:0] cnt_inc_s;
  logic          pulse_s;
  logic          level_r;
  logic          pulse_r;

  // Synchronize the raw active-low input into an active-high pressed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= ~push_but;
      sync_r <= meta_r;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= (state_s == HELD) || (state_s == REPEAT) || (state_s == DEB_REL);
      pulse_r <= pulse_s && !pulse_r;
    end
  end

  // Next-state logic; everything advances only on the shared 1 ms tick.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pulse_s   = 1'b0;
    cnt_inc_s = cnt_r + CW'(1);
    if (tick) begin
      case (state_r)
        IDLE: begin
          if (sync_r) begin
            state_s = DEB_PRESS;
            cnt_s   = CW'(1);
          end else begin
            state_s = IDLE;
            cnt_s   = '0;
          end
        end
        DEB_PRESS: begin
          if (!sync_r) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else if (cnt_inc_s == CW'(DEB_MS)) begin
            state_s = HELD;
            cnt_s   = '0;
            pulse_s = 1'b1;
          end else begin
            cnt_s   = cnt_inc_s;
          end
        end
        HELD: begin
          // Release wins over a coincident hold expiry.
          if (!sync_r) begin
            state_s = DEB_REL;
            cnt_s   = CW'(1);
`ifdef BTN_AUTOREPEAT_EN
          end else if (cnt_inc_s == CW'(HOLD_MS)) begin
            state_s = REPEAT;
            cnt_s   = '0;
            pulse_s = 1'b1;
          end else begin
            cnt_s   = cnt_inc_s;
          end
`else
          end else begin
            state_s = HELD;
            cnt_s   = cnt_r;
          end
`endif
        end
`ifdef BTN_AUTOREPEAT_EN
        REPEAT: begin
          if (!sync_r) begin
            state_s = DEB_REL;
            cnt_s   = CW'(1);
          end else if (cnt_inc_s == CW'(RPT_MS)) begin
            cnt_s   = '0;
            pulse_s = 1'b1;
          end else begin
            cnt_s   = cnt_inc_s;
          end
        end
`endif
        DEB_REL: begin
          if (sync_r) begin
            state_s = HELD;
            cnt_s   = '0;
          end else if (cnt_inc_s == CW'(DEB_MS)) begin
            state_s = IDLE;
            cnt_s   = '0;
          end else begin
            cnt_s   = cnt_inc_s;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
        end
      endcase
    end else begin
      state_s = state_r;
      cnt_s   = cnt_r;
    end
  end

  assign pb_level = level_r;
  assign pb_pulse = pulse_r;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: shared 1 ms tick and one btn_fsm per button.
// Define BTN_AUTOREPEAT_EN to enable hold-to-repeat increment pulses.
module btn_conditioner
  import rtc_pkg::*;
#(
  parameter int N_BTN    = 3,
  parameter int TICK_DIV = TICK_DIV_50M,
  parameter int DEB_MS   = DEB_MS_DEF,
  parameter int HOLD_MS  = HOLD_MS_DEF,
  parameter int RPT_MS   = RPT_MS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] push_but,
  output logic [N_BTN-1:0] pb_level,
  output logic [N_BTN-1:0] pb_pulse
);

  localparam int TW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;

  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;

  assign tick_s = (tick_cnt_r == TW'(TICK_DIV));

  // Free-running divider producing a one-cycle tick every TICK_DIV+1 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + TW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_fsm #(
      .DEB_MS  (DEB_MS),
      .HOLD_MS (HOLD_MS),
      .RPT_MS  (RPT_MS)
    ) u_btn_fsm (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick_s),
      .push_but (push_but[i]),
      .pb_level (pb_level[i]),
      .pb_pulse (pb_pulse[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 3, number of independent push buttons (bit 0 seconds, 1 minutes, 2 hours).
REQ-002 SHALL have parameter TICK_DIV, default 49999, clock cycles per 1 ms tick minus one (50 MHz clk).
REQ-003 SHALL have parameter DEB_MS, default 10, consecutive stable ticks required to accept a press or release.
REQ-004 SHALL have parameter HOLD_MS, default 500, ticks held before the first auto-repeat pulse.
REQ-005 SHALL have parameter RPT_MS, default 100, ticks between subsequent auto-repeat pulses.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz; the only clock.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port push_but  input  N_BTN  raw asynchronous buttons, active-low (1 = released).
REQ-009 SHALL have port pb_level  output  N_BTN  debounced pressed state, active-high.
REQ-010 SHALL have port pb_pulse  output  N_BTN  one-cycle increment request, active-high, feeds the time-set increment logic.

Function
REQ-011 Each push_but bit SHALL pass through a two-flop synchronizer, inverted to active-high, before any use.
REQ-012 A free-running tick counter SHALL assert an internal tick for exactly one cycle every TICK_DIV+1 cycles; all FSM timing advances only on tick.
REQ-013 Each button SHALL run an independent FSM with states IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL, plus a tick counter of width $clog2(HOLD_MS+1).
REQ-014 IDLE: on a tick with the synchronized input pressed -> DEB_PRESS, count=1.
REQ-015 DEB_PRESS: on a tick with input pressed, count+1; when count reaches DEB_MS -> HELD, count=0, pb_level=1, pb_pulse=1 for the next cycle only; on a tick with input released -> IDLE, count=0, no pulse.
REQ-016 HELD: count+1 per tick; when count reaches HOLD_MS -> REPEAT, count=0, one pb_pulse.
REQ-017 REPEAT: count+1 per tick; when count reaches RPT_MS -> one pb_pulse, count=0; remain in REPEAT.
REQ-018 HELD or REPEAT: on a tick with input released -> DEB_REL, count=1; release check takes priority over a coincident hold/repeat expiry (no pulse).
REQ-019 DEB_REL: on a tick with input released, count+1; when count reaches DEB_MS -> IDLE, pb_level=0; on a tick with input pressed -> HELD, count=0 (hold timer restarts, no pulse).
REQ-020 pb_pulse and pb_level SHALL be registered outputs; pb_pulse is never high for two consecutive cycles.
REQ-021 Buttons SHALL be fully independent; simultaneous presses each produce their own pulses in the same cycle.

Reset
REQ-022 While rst=1 at a clk edge: synchronizers to released, tick counter 0, all FSMs IDLE, counts 0, pb_level=0, pb_pulse=0.
REQ-023 Reset asserted mid-press SHALL discard the press; after release of rst, a still-held button SHALL be re-debounced from IDLE and produce a fresh first pulse.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN: when defined, REPEAT state and REQ-016/REQ-017 pulses are present.
REQ-025 Without BTN_AUTOREPEAT_EN: REPEAT state is not compiled; HELD persists until release with no further pulses; exactly one pb_pulse per debounced press.

Structure
REQ-026 Package rtc_pkg SHALL hold the btn_state_t enum (IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL) and default timing constants (TICK_DIV_50M, DEB_MS_DEF, HOLD_MS_DEF, RPT_MS_DEF).
REQ-027 One sub-module btn_fsm SHALL implement a single button's synchronizer and FSM; btn_conditioner owns the shared tick counter and instantiates N_BTN btn_fsm via generate.

Verification (TICK_DIV=9, DEB_MS=3, HOLD_MS=5, RPT_MS=2)
REQ-028 push_but[0] low steady -> pb_pulse[0] single cycle 3 ticks after first sampled tick, pb_level[0]=1; others stay 0.
REQ-029 push_but[1] low for 2 ticks then high -> no pb_pulse[1], pb_level[1] stays 0, FSM back in IDLE.
REQ-030 push_but[2] held 20 ticks with BTN_AUTOREPEAT_EN -> pulses at tick 3, 8, 10, 12, ...; without macro -> single pulse at tick 3.
REQ-031 Hold button, 1-tick release bounce -> no extra pulse, pb_level stays 1; 3-tick release -> pb_level=0.
REQ-032 rst pulsed at tick 2 of DEB_PRESS with button still low -> outputs 0 during reset, first pulse 3 ticks after the first post-reset sampled tick.
REQ-033 All three buttons pressed in the same cycle -> pb_pulse=3'b111 in one cycle.
